memgame_ctrl: RTL and testbench
===============================

Name: memgame_ctrl

Overview:
Top-level sequencer for the memorization game. Each round it generates a 4-digit target (digits 0-8) from a free-running LFSR and shows it for a fixed time. It then blanks the display, collects four user digits from the keypad strobe, compares the entry with the target, and updates score and lives. It drives the 7-segment display mux and the status LEDs.

Parameters:
SHOW_CYCLES, 100000000, clock cycles the target is displayed (1 s at 100 MHz)
RESULT_CYCLES, 50000000, clock cycles the result is held before the next round
LIVES, 3, lives at game start (1-3)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)
TIMEOUT_CYCLES, 500000000, entry idle timeout (used only with ENTRY_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse to begin or restart a game
digit_valid  in  1  one-cycle strobe; digit_in is valid this cycle
digit_in  in  4  keypad digit
clear  in  1  one-cycle pulse; discards the partial entry
display  out  16  four nibbles to the 7-seg mux; [15:12] leftmost; 4'hF = blank
target  out  16  current target, four nibbles
state  out  3  FSM state code
correct  out  1  result of the last check
result_valid  out  1  high during RESULT
score  out  8  rounds won, saturating at 255
lives  out  2  remaining lives
game_over  out  1  high in OVER

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, display=16'hFFFF, target=0, correct=0, result_valid=0, score=0, lives=LIVES, game_over=0, lfsr=LFSR_SEED, counters=0. rst overrides all other inputs, including mid-round.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle when not in reset.
- State codes: IDLE=0, GEN=1, SHOW=2, ENTRY=3, CHECK=4, RESULT=5, OVER=6.
- IDLE: display blank; on start -> GEN.
- GEN (1 cycle): target[4k+3:4k] = n>=9 ? n-9 : n, where n = lfsr[4k+3:4k]. Entry buffer cleared to 16'hFFFF. Next state is SHOW.
- SHOW: display=target for exactly SHOW_CYCLES cycles, then ENTRY.
- ENTRY: display=entry buffer.
  - An accepted digit (digit_valid=1 and digit_in<=8) shifts in from the right. Entry count is 0..4. After the first digit the buffer is 16'hFFF<d0>, after the fourth it is <d0><d1><d2><d3>.
  - Digits >8 are ignored. digit_valid is ignored in every state except ENTRY.
  - clear sets the buffer to 16'hFFFF and the count to 0. If clear and digit_valid arrive in the same cycle, clear wins.
  - The cycle after the 4th accepted digit, state goes to CHECK.
- CHECK (1 cycle): correct = (buffer == target).
  - If correct: score increments, saturating at 255.
  - Else: lives decrements.
  - Next state is RESULT.
- RESULT: result_valid=1. Display=16'h0000 if correct, else 16'hFFFF. Held for RESULT_CYCLES cycles, then:
  - lives==0 -> OVER
  - otherwise -> GEN (next round, no start needed).
- OVER: game_over=1, display blank. On start: score=0, lives=LIVES, correct=0, then GEN.
- start outside IDLE/OVER is ignored. A game is aborted only by rst.
- Latency: start at edge N gives GEN at N+1 and SHOW at N+2. The 4th digit at edge M gives CHECK at M+1, with correct/score/lives updated at M+2.
- All outputs are registered.

Optional Feature:
ENTRY_TIMEOUT_EN: when defined, an idle counter runs in ENTRY and resets on every accepted digit and on clear. On reaching TIMEOUT_CYCLES it forces CHECK with the current buffer, which is unfilled and therefore fails: correct=0 and lives decrements. When undefined, no counter exists and ENTRY waits indefinitely.

Test Plan:
All scenarios use SHOW_CYCLES=4, RESULT_CYCLES=2, LIVES=3, TIMEOUT_CYCLES=8.
- Reset check: rst high 2 cycles -> state=0, display=16'hFFFF, score=0, lives=3, game_over=0.
- Winning round: start; capture target during SHOW; enter its 4 digits -> SHOW lasts exactly 4 cycles, correct=1, score=1, lives=3, result_valid high 2 cycles, then state=1.
- Rejection and clear: in ENTRY enter 9, then 5, then clear, then the target digits -> the 9 is ignored, display=16'hFFF5 before clear, 16'hFFFF after; final correct=1.
- Game over: three wrong entries (target nibble0 XOR 1) -> lives 3->2->1->0, then state=6 and game_over=1. Then start -> score=0, lives=3, state=1.
- Simultaneous events:
  - digit_valid with clear -> buffer stays 16'hFFFF.
  - rst during ENTRY with 2 digits entered -> IDLE, display 16'hFFFF.
  - start during SHOW -> no effect.
- ENTRY_TIMEOUT_EN: enter 1 digit, then idle 8 cycles -> CHECK, correct=0, lives=2. Without the macro, state stays 3 after 100 idle cycles.

Source files
------------

// File: rtl/memgame_ctrl_if.sv
// Keypad/display bundle for the memorization game sequencer.
// slave: controller side; master: keypad/host side.
interface memgame_ctrl_if;
  logic        start;
  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        clear;
  logic [15:0] display;
  logic [15:0] target;
  logic [2:0]  state;
  logic        correct;
  logic        result_valid;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over;

  modport slave (
    input  start, digit_valid, digit_in, clear,
    output display, target, state, correct,
    output result_valid, score, lives, game_over
  );

  modport master (
    output start, digit_valid, digit_in, clear,
    input  display, target, state, correct,
    input  result_valid, score, lives, game_over
  );
endinterface

// File: rtl/memgame_ctrl.sv
// Memorization game sequencer: LFSR target, show, entry, check, score.
// Ports: clk, rst (sync, active high), bus (memgame_ctrl_if.slave):
//   in  start, digit_valid, digit_in[3:0], clear
//   out display[15:0], target[15:0], state[2:0], correct,
//       result_valid, score[7:0], lives[1:0], game_over
// Optional macro ENTRY_TIMEOUT_EN: forces CHECK after an idle
// stretch of TIMEOUT_CYCLES in ENTRY.
module memgame_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 100000000,
  parameter int unsigned RESULT_CYCLES  = 50000000,
  parameter int unsigned LIVES          = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input logic           clk,
  input logic           rst,
  memgame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_SHOW   = 3'd2,
    S_ENTRY  = 3'd3,
    S_CHECK  = 3'd4,
    S_RESULT = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  // One counter serves SHOW, RESULT and the entry idle timer.
  localparam int unsigned M1 =
    (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int unsigned M2 =
    (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW = (M2 < 2) ? 1 : $clog2(M2 + 1);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(RESULT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
`ifdef ENTRY_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   target_q, target_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    num_q, num_d;
  logic          correct_q, correct_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [15:0]   display_q, display_d;
  logic          rv_q, rv_d;
  logic          over_q, over_d;
  logic          accept;

  // Fold a raw nibble into 0..8.
  function automatic logic [3:0] fold(input logic [3:0] n);
    return (n >= 4'd9) ? (n - 4'd9) : n;
  endfunction

  assign accept = bus.digit_valid && (bus.digit_in <= 4'd8);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    buf_d     = buf_q;
    num_d     = num_q;
    correct_d = correct_q;
    score_d   = score_q;
    lives_d   = lives_q;
    lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400)
                          : (lfsr_q >> 1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_GEN;
      end
      S_GEN: begin
        target_d = {fold(lfsr_q[15:12]), fold(lfsr_q[11:8]),
                    fold(lfsr_q[7:4]),   fold(lfsr_q[3:0])};
        buf_d    = 16'hFFFF;
        num_d    = 3'd0;
        cnt_d    = '0;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = S_ENTRY;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ENTRY: begin
        // clear outranks a same-cycle digit
        priority case (1'b1)
          bus.clear: begin
            buf_d = 16'hFFFF;
            num_d = 3'd0;
            cnt_d = '0;
          end
          accept: begin
            buf_d = {buf_q[11:0], bus.digit_in};
            num_d = num_q + 3'd1;
            cnt_d = '0;
            if (num_q == 3'd3) state_d = S_CHECK;
          end
          default: begin
`ifdef ENTRY_TIMEOUT_EN
            if (cnt_q == TO_LAST) begin
              cnt_d   = '0;
              state_d = S_CHECK;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
`endif
          end
        endcase
      end
      S_CHECK: begin
        correct_d = (buf_q == target_q);
        if (buf_q == target_q) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end else begin
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
        cnt_d   = '0;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (cnt_q == RES_LAST) begin
          cnt_d   = '0;
          state_d = (lives_q == 2'd0) ? S_OVER : S_GEN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          score_d   = 8'd0;
          lives_d   = LIVES_INIT;
          correct_d = 1'b0;
          state_d   = S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state view.
    display_d = 16'hFFFF;
    unique case (state_d)
      S_SHOW:           display_d = target_d;
      S_ENTRY, S_CHECK: display_d = buf_d;
      S_RESULT:         display_d = correct_d ? 16'h0000
                                              : 16'hFFFF;
      default:          display_d = 16'hFFFF;
    endcase
    rv_d   = (state_d == S_RESULT);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      target_q  <= 16'h0000;
      buf_q     <= 16'hFFFF;
      num_q     <= 3'd0;
      correct_q <= 1'b0;
      score_q   <= 8'd0;
      lives_q   <= LIVES_INIT;
      display_q <= 16'hFFFF;
      rv_q      <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      buf_q     <= buf_d;
      num_q     <= num_d;
      correct_q <= correct_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      display_q <= display_d;
      rv_q      <= rv_d;
      over_q    <= over_d;
    end
  end

  assign bus.display      = display_q;
  assign bus.target       = target_q;
  assign bus.state        = state_q;
  assign bus.correct      = correct_q;
  assign bus.result_valid = rv_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = over_q;

endmodule

// File: tb/tb_memgame_ctrl.sv
// Bench for memgame_ctrl: directed rounds with a result scoreboard.
// Build with +define+ENTRY_TIMEOUT_EN to cover the idle timeout.
module tb_memgame_ctrl;
  localparam int unsigned SHOW = 4;
  localparam int unsigned RES  = 2;
  localparam int unsigned LIV  = 3;
  localparam int unsigned TO   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memgame_ctrl_if ifc();

  memgame_ctrl #(
    .SHOW_CYCLES(SHOW),
    .RESULT_CYCLES(RES),
    .LIVES(LIV),
    .LFSR_SEED(SEED),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic       correct;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] nxt;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_score;
  logic [1:0] exp_lives;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference LFSR and target capture.
  function automatic logic [3:0] fold(input logic [3:0] n);
    return (n >= 4'd9) ? (n - 4'd9) : n;
  endfunction

  logic [15:0] m_lfsr;
  logic [15:0] m_tgt = 16'h0;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400)
                             : (m_lfsr >> 1);
    if (!rst && ifc.state == 3'd1)
      m_tgt <= {fold(m_lfsr[15:12]), fold(m_lfsr[11:8]),
                fold(m_lfsr[7:4]), fold(m_lfsr[3:0])};
  end

  // Monitor: one scoreboard entry per RESULT phase.
  initial begin
    exp_t cur;
    int len;
    logic prev;
    cur  = '0;
    len  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        len  = 0;
      end else begin
        if (ifc.result_valid && !prev) begin
          len = 0;
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got result, want none");
          end else begin
            cur = sbq.pop_front();
            chk("res_correct", 32'(ifc.correct), 32'(cur.correct));
            chk("res_score", 32'(ifc.score), 32'(cur.score));
            chk("res_lives", 32'(ifc.lives), 32'(cur.lives));
            chk("res_display", 32'(ifc.display),
                cur.correct ? 32'h0000 : 32'hFFFF);
          end
        end
        if (ifc.result_valid) len++;
        if (!ifc.result_valid && prev) begin
          chk("res_len", 32'(len), 32'(RES));
          chk("res_next", 32'(ifc.state), 32'(cur.nxt));
        end
        prev = ifc.result_valid;
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget,
                            input string nm);
    int k;
    k = 0;
    while (ifc.state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(ifc.state), 32'(s));
  endtask

  task automatic key(input logic [3:0] d);
    ifc.digit_valid = 1'b1;
    ifc.digit_in    = d;
    @(negedge clk);
    ifc.digit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Waits for SHOW, checks target and length; optionally pokes start.
  task automatic show_phase(input bit poke, input string nm);
    int len;
    wait_state(3'd2, 20, {nm, "_show"});
    chk({nm, "_target"}, 32'(ifc.target), 32'(m_tgt));
    chk({nm, "_disp"}, 32'(ifc.display), 32'(m_tgt));
    len = 1;
    for (int k = 0; k < 20; k++) begin
      ifc.start = poke;
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.state == 3'd2) len++;
      else break;
    end
    chk({nm, "_showlen"}, 32'(len), 32'(SHOW));
    chk({nm, "_entry"}, 32'(ifc.state), 32'd3);
  endtask

  task automatic enter(input logic [15:0] v, input bit ok,
                       output logic [2:0] nxt);
    exp_t e;
    if (ok) begin
      if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
    end else begin
      exp_lives = exp_lives - 2'd1;
    end
    nxt       = (exp_lives == 2'd0) ? 3'd6 : 3'd1;
    e.correct = ok;
    e.score   = exp_score;
    e.lives   = exp_lives;
    e.nxt     = nxt;
    sbq.push_back(e);
    key(v[15:12]);
    key(v[11:8]);
    key(v[7:4]);
    key(v[3:0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  nxt;
    logic [15:0] wrong;
    logic [3:0]  lo;
    ifc.start       = 1'b0;
    ifc.digit_valid = 1'b0;
    ifc.digit_in    = 4'd0;
    ifc.clear       = 1'b0;
    exp_score       = 8'd0;
    exp_lives       = 2'(LIV);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(ifc.state), 32'd0);
    chk("rst_display", 32'(ifc.display), 32'hFFFF);
    chk("rst_score", 32'(ifc.score), 32'd0);
    chk("rst_lives", 32'(ifc.lives), 32'(LIV));
    chk("rst_over", 32'(ifc.game_over), 32'd0);
    chk("rst_rv", 32'(ifc.result_valid), 32'd0);
    rst = 1'b0;

    // Winning round.
    pulse_start();
    chk("gen_after_start", 32'(ifc.state), 32'd1);
    show_phase(1'b0, "r1");
    enter(m_tgt, 1'b1, nxt);
    chk("r1_check", 32'(ifc.state), 32'd4);
    wait_state(nxt, 20, "r1_next");

    // Rejected digit and clear, then a win.
    show_phase(1'b0, "r2");
    key(4'd9);
    chk("r2_ign9", 32'(ifc.display), 32'hFFFF);
    key(4'd5);
    chk("r2_five", 32'(ifc.display), 32'hFFF5);
    ifc.clear = 1'b1;
    @(negedge clk);
    ifc.clear = 1'b0;
    chk("r2_clear", 32'(ifc.display), 32'hFFFF);
    enter(m_tgt, 1'b1, nxt);
    wait_state(nxt, 20, "r2_next");

    // Three losses end the game.
    for (int r = 0; r < 3; r++) begin
      show_phase(1'b0, "lose");
      lo    = m_tgt[3:0];
      lo    = (lo == 4'd8) ? 4'd0 : (lo ^ 4'd1);
      wrong = {m_tgt[15:4], lo};
      enter(wrong, 1'b0, nxt);
      wait_state(nxt, 20, "lose_next");
    end
    chk("over_state", 32'(ifc.state), 32'd6);
    chk("over_flag", 32'(ifc.game_over), 32'd1);
    chk("over_disp", 32'(ifc.display), 32'hFFFF);

    // Restart from OVER.
    pulse_start();
    exp_score = 8'd0;
    exp_lives = 2'(LIV);
    chk("restart_state", 32'(ifc.state), 32'd1);
    chk("restart_score", 32'(ifc.score), 32'd0);
    chk("restart_lives", 32'(ifc.lives), 32'(LIV));
    chk("restart_correct", 32'(ifc.correct), 32'd0);

    // start held through SHOW has no effect.
    show_phase(1'b1, "poke");

    // Digit together with clear: clear wins.
    ifc.digit_valid = 1'b1;
    ifc.digit_in    = 4'd3;
    ifc.clear       = 1'b1;
    @(negedge clk);
    ifc.digit_valid = 1'b0;
    ifc.clear       = 1'b0;
    chk("dv_clear", 32'(ifc.display), 32'hFFFF);
    key(4'd1);
    key(4'd2);
    chk("two_digits", 32'(ifc.display), 32'hFF12);

    // Reset mid-entry.
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(ifc.state), 32'd0);
    chk("midrst_disp", 32'(ifc.display), 32'hFFFF);
    rst = 1'b0;
    exp_score = 8'd0;
    exp_lives = 2'(LIV);

    // Idle in ENTRY.
    pulse_start();
    show_phase(1'b0, "idle");
    key(4'd1);
    chk("idle_one", 32'(ifc.display), 32'hFFF1);
`ifdef ENTRY_TIMEOUT_EN
    begin
      exp_t e;
      int k;
      exp_lives = exp_lives - 2'd1;
      e.correct = 1'b0;
      e.score   = exp_score;
      e.lives   = exp_lives;
      e.nxt     = 3'd1;
      sbq.push_back(e);
      k = 0;
      while (ifc.state == 3'd3 && k < 30) begin
        @(negedge clk);
        k++;
      end
      chk("to_cycles", 32'(k), 32'(TO));
      chk("to_check", 32'(ifc.state), 32'd4);
      wait_state(3'd1, 20, "to_next");
    end
`else
    repeat (100) @(negedge clk);
    chk("no_timeout", 32'(ifc.state), 32'd3);
    chk("no_timeout_disp", 32'(ifc.display), 32'hFFF1);
`endif

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
